rtc_sda_in_capture: RTL

RTC_SDA_IN_CAPTURE -- requirements
Module: rtc_sda_in_capture

---
 rtl/rtc_sda_in_capture.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rtc_sda_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : rtc_sda_in_capture
// Purpose  : Avalon-MM input capture for the RTC SDA line. The pin is
//            synchronized through two flops, optionally glitch-filtered, and
//            the filtered level f is exposed together with an edge-capture
//            flag and a maskable level interrupt.
// Ports    : clk         - single clock
//            reset       - asynchronous, active-high reset
//            address     - word address (0=f, 1=reserved, 2=irq_mask,
//                          3=edge_capture, write 1 to clear)
//            chipselect  - slave select (write qualifier only)
//            write_n     - active-low write strobe
//            writedata   - write data, bit 0 used
//            readdata    - combinational read data, bits 31:1 zero
//            in_port     - asynchronous SDA pin input
//            irq         - level interrupt = edge_capture & irq_mask
// Config   : define RTC_SDA_GLITCH_FILTER_EN to enable the FILTER_CYCLES
//            stability filter between the synchronizer and f.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_sda_in_capture #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq
);

    localparam logic [1:0] c_addr_data = 2'd0;
    localparam logic [1:0] c_addr_mask = 2'd2;
    localparam logic [1:0] c_addr_edge = 2'd3;

    logic r_s1;
    logic r_s2;
    logic r_f;
    logic r_irq_mask;
    logic r_edge_capture;

    logic w_f_next;
    logic w_write;
    logic w_edge_event;
    logic w_clear;

    // Upper write-data bits carry no meaning in this register map.
    logic w_unused_writedata;
    assign w_unused_writedata = &{1'b0, writedata[31:1]};

    // Two-flop synchronizer; resets to the idle-high bus level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

`ifdef RTC_SDA_GLITCH_FILTER_EN
    localparam logic [7:0] c_filter_last = 8'(FILTER_CYCLES - 1);

    logic [7:0] r_filter_cnt;
    logic [7:0] w_filter_cnt_next;

    // A pending change must persist FILTER_CYCLES clocks; any return to the
    // current filtered level restarts the count from zero.
    always_comb begin
        w_f_next          = r_f;
        w_filter_cnt_next = 8'd0;
        if (r_s2 != r_f) begin
            if (r_filter_cnt == c_filter_last) begin
                w_f_next          = r_s2;
                w_filter_cnt_next = 8'd0;
            end else begin
                w_filter_cnt_next = r_filter_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filter_cnt <= 8'd0;
        end else begin
            r_filter_cnt <= w_filter_cnt_next;
        end
    end
`else
    localparam int c_unused_filter_cycles = FILTER_CYCLES;

    always_comb begin
        w_f_next = r_s2;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f <= 1'b1;
        end else begin
            r_f <= w_f_next;
        end
    end

    // Edge detection looks at the next filtered value so the flag sets on the
    // same edge f changes.
    assign w_edge_event = (w_f_next != r_f);
    assign w_write      = chipselect & ~write_n;
    assign w_clear      = w_write & (address == c_addr_edge) & writedata[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= 1'b0;
        end else if (w_write && (address == c_addr_mask)) begin
            r_irq_mask <= writedata[0];
        end
    end

    // Set has priority over a coincident clear so no edge is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_capture <= 1'b0;
        end else if (w_edge_event) begin
            r_edge_capture <= 1'b1;
        end else if (w_clear) begin
            r_edge_capture <= 1'b0;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            c_addr_data: readdata = {31'd0, r_f};
            c_addr_mask: readdata = {31'd0, r_irq_mask};
            c_addr_edge: readdata = {31'd0, r_edge_capture};
            default:     readdata = 32'd0;
        endcase
    end

    assign irq = r_edge_capture & r_irq_mask;

endmodule
`default_nettype wire
